// File: rtl/axis_stream_packet_source_pkg.sv
// Shared types and helpers for the AXI-Stream packet source.
package axis_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  localparam int unsigned DATAWIDTH_DEFAULT = 32;
  localparam int unsigned BYTES             = DATAWIDTH_DEFAULT / 8;
  localparam int unsigned MAX_BYTES         = 128;

  // Low r bytes enabled; callers slice the result to their own byte count.
  function automatic logic [MAX_BYTES-1:0] strb_mask(input int unsigned r);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < r);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_stream_packet_source_if.sv
// AXI-Stream beat bundle (data, strobes, handshake, framing).
interface axis_stream_packet_source_if #(
  parameter int unsigned DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0]   tdata;
  logic [DATAWIDTH/8-1:0] tstrb;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata,
    output tstrb,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tstrb,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_stream_packet_source_framer.sv
// Per-packet beat counter producing registered tlast/tstrb for the presented beat.
module axis_beat_framer
  import axis_stream_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned LENWIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LENWIDTH-1:0]    i_len,
  input  logic                   i_first,
  input  logic                   i_next,
  input  logic                   i_clear,
  output logic                   o_last,
  output logic [DATAWIDTH/8-1:0] o_strb
);

  localparam int unsigned NBYTES = DATAWIDTH / 8;

  logic [LENWIDTH:0]    w_numBeats;
  logic [LENWIDTH:0]    w_lastIdx;
  logic [LENWIDTH-1:0]  w_rem;
  logic [LENWIDTH-1:0]  w_beat;
  logic [LENWIDTH-1:0]  r_beat;
  logic [MAX_BYTES-1:0] w_maskFull;
  logic [NBYTES-1:0]    w_lastStrb;
  logic                 w_isLast;

  always_comb begin
    w_numBeats = ({1'b0, i_len} + (LENWIDTH+1)'(NBYTES - 1)) / (LENWIDTH+1)'(NBYTES);
    w_lastIdx  = w_numBeats - (LENWIDTH+1)'(1);
    w_rem      = i_len % LENWIDTH'(NBYTES);
    w_maskFull = strb_mask(32'(w_rem));
    w_lastStrb = (w_rem == '0) ? '1 : w_maskFull[NBYTES-1:0];
    // Flags are computed for the beat about to be presented, not the current one.
    w_beat     = i_first ? '0 : r_beat + LENWIDTH'(1);
    w_isLast   = ({1'b0, w_beat} == w_lastIdx);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat <= '0;
      o_last <= 1'b0;
      o_strb <= '0;
    end else if (i_clear) begin
      o_last <= 1'b0;
      o_strb <= '0;
    end else if (i_first || i_next) begin
      r_beat <= w_beat;
      o_last <= w_isLast;
      o_strb <= w_isLast ? w_lastStrb : '1;
    end
  end

endmodule

// File: rtl/axis_stream_packet_source.sv
// AXI-Stream packet generator: incrementing data, multi-packet runs, gaps, partial last beats.
module axis_stream_packet_source
  import axis_stream_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned LENWIDTH  = 16
) (
  input  logic                          dataOut_tclk,
  input  logic                          dataOut_treset,
  input  logic                          start,
  input  logic [LENWIDTH-1:0]           cfg_lengthBytes,
  input  logic [LENWIDTH-1:0]           cfg_numPackets,
  input  logic [7:0]                    cfg_gapCycles,
  input  logic [DATAWIDTH-1:0]          cfg_seed,
  axis_stream_packet_source_if.master   dataOut,
  output logic                          busy,
  output logic                          done,
  output logic [LENWIDTH-1:0]           packetCount
);

  state_t                r_state;
  logic [LENWIDTH-1:0]   r_len;
  logic [LENWIDTH-1:0]   r_pktsLeft;
  logic [7:0]            r_gap;
  logic [7:0]            r_gapCnt;
  logic                  r_tvalid;
  logic [DATAWIDTH-1:0]  r_tdata;
  logic                  r_busy;
  logic                  r_done;
  logic [LENWIDTH-1:0]   r_pktCount;

  logic                   w_accept;
  logic [LENWIDTH-1:0]    w_len;
  logic                   w_first;
  logic                   w_next;
  logic                   w_clear;
  logic                   w_last;
  logic [DATAWIDTH/8-1:0] w_strb;

  assign w_accept = r_tvalid && dataOut.tready;

  // In IDLE the framer must see the incoming length, since it is latched on the same edge.
  always_comb begin
    w_len   = (r_state == IDLE) ? cfg_lengthBytes : r_len;
    w_first = 1'b0;
    w_next  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      IDLE: w_first = start && (cfg_lengthBytes != '0) && (cfg_numPackets != '0);
      SEND: begin
        if (w_accept) begin
          if (!w_last)                                  w_next  = 1'b1;
          else if ((r_pktsLeft != '0) && (r_gap == '0)) w_first = 1'b1;
          else                                          w_clear = 1'b1;
        end
      end
      GAP:     w_first = (r_gapCnt == 8'd1);
      default: ;
    endcase
  end

  axis_beat_framer #(
    .DATAWIDTH (DATAWIDTH),
    .LENWIDTH  (LENWIDTH)
  ) u_framer (
    .i_clk   (dataOut_tclk),
    .i_rst   (dataOut_treset),
    .i_len   (w_len),
    .i_first (w_first),
    .i_next  (w_next),
    .i_clear (w_clear),
    .o_last  (w_last),
    .o_strb  (w_strb)
  );

  always_ff @(posedge dataOut_tclk or posedge dataOut_treset) begin
    if (dataOut_treset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_pktsLeft <= '0;
      r_gap      <= '0;
      r_gapCnt   <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pktCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_len      <= cfg_lengthBytes;
            r_gap      <= cfg_gapCycles;
            r_pktsLeft <= cfg_numPackets - LENWIDTH'(1);
            r_tdata    <= cfg_seed;
            r_busy     <= 1'b1;
            if ((cfg_lengthBytes == '0) || (cfg_numPackets == '0)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= SEND;
              r_tvalid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (w_accept) begin
            r_tdata <= r_tdata + DATAWIDTH'(1);
            if (w_last) begin
              r_pktCount <= r_pktCount + LENWIDTH'(1);
              if (r_pktsLeft != '0) begin
                r_pktsLeft <= r_pktsLeft - LENWIDTH'(1);
                if (r_gap != '0) begin
                  r_state  <= GAP;
                  r_gapCnt <= r_gap;
                  r_tvalid <= 1'b0;
                end
              end else begin
                r_state  <= DONE;
                r_tvalid <= 1'b0;
                r_done   <= 1'b1;
              end
            end
          end
        end
        GAP: begin
          if (r_gapCnt == 8'd1) begin
            r_state  <= SEND;
            r_tvalid <= 1'b1;
          end else begin
            r_gapCnt <= r_gapCnt - 8'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dataOut.tvalid = r_tvalid;
  assign dataOut.tdata  = r_tdata;
  assign dataOut.tstrb  = w_strb;
  assign dataOut.tlast  = w_last;
  assign busy           = r_busy;
  assign done           = r_done;
  assign packetCount    = r_pktCount;

endmodule

// File: tb/tb_axis_stream_packet_source.sv
// Directed bench with beat scoreboard for axis_stream_packet_source (32-bit data).
module tb_axis_stream_packet_source;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_pkts = '0;
  logic [7:0]  cfg_gap = '0;
  logic [31:0] cfg_seed = '0;
  logic        busy, done;
  logic [15:0] pcount;

  int    n_total = 0;
  int    n_pass  = 0;
  int    pc_exp  = 0;
  beat_t sb[$];
  beat_t hold;
  bit    stall = 1'b0;

  axis_stream_packet_source_if #(.DATAWIDTH(32)) axis ();

  axis_stream_packet_source #(
    .DATAWIDTH (32),
    .LENWIDTH  (16)
  ) dut (
    .dataOut_tclk    (clk),
    .dataOut_treset  (rst),
    .start           (start),
    .cfg_lengthBytes (cfg_len),
    .cfg_numPackets  (cfg_pkts),
    .cfg_gapCycles   (cfg_gap),
    .cfg_seed        (cfg_seed),
    .dataOut         (axis),
    .busy            (busy),
    .done            (done),
    .packetCount     (pcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: stability under backpressure and in-order scoreboard popping.
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_tvalid", axis.tvalid, 1);
        chk("stall_tdata",  axis.tdata,  hold.d);
        chk("stall_tstrb",  axis.tstrb,  hold.s);
        chk("stall_tlast",  axis.tlast,  hold.l);
      end
      if (axis.tvalid && axis.tready) begin
        n_total = n_total + 1;
        assert (sb.size() != 0) n_pass = n_pass + 1;
        else $error("FAIL unexpected_beat: got data %0h expected no beat", axis.tdata);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_tdata", axis.tdata, e.d);
          chk("beat_tstrb", axis.tstrb, e.s);
          chk("beat_tlast", axis.tlast, e.l);
        end
      end
      stall = axis.tvalid && !axis.tready;
      hold  = '{d: axis.tdata, s: axis.tstrb, l: axis.tlast};
    end
  end

  task automatic push_expected(input int len, input int pkts, input logic [31:0] seed);
    int          nb;
    int          r;
    logic [31:0] idx;
    beat_t       b;
    nb  = (len + 3) / 4;
    r   = len % 4;
    idx = '0;
    for (int p = 0; p < pkts; p++) begin
      for (int k = 0; k < nb; k++) begin
        b.d = seed + idx;
        b.l = (k == nb - 1);
        b.s = (b.l && r != 0) ? 4'((1 << r) - 1) : 4'hF;
        sb.push_back(b);
        idx = idx + 1;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the block is back in IDLE.
  task automatic run(input int len, input int pkts, input int gap, input logic [31:0] seed,
                     input bit bp, input bit poke, input int exp_cnt, input logic [63:0] exp_pat);
    logic [63:0] pat;
    int          cnt;
    bit          seen;
    if (len != 0 && pkts != 0) begin
      push_expected(len, pkts, seed);
      pc_exp = pc_exp + pkts;
    end
    cfg_len  = 16'(len);
    cfg_pkts = 16'(pkts);
    cfg_gap  = 8'(gap);
    cfg_seed = seed;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cfg_len  = 16'($urandom_range(1, 40));
    cfg_pkts = 16'($urandom_range(1, 5));
    cfg_gap  = 8'($urandom_range(0, 3));
    cfg_seed = $urandom;
    if (bp) axis.tready = 1'($urandom_range(0, 1));
    pat  = '0;
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      pat = {pat[62:0], axis.tvalid};
      cnt = cnt + 1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (bp) axis.tready = 1'($urandom_range(0, 1));
      if (poke) start = (c == 0);
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    if (exp_cnt != 0) begin
      chk("valid_cycles", cnt, exp_cnt);
      chk("valid_pattern", pat, exp_pat);
    end
    @(posedge clk); #1;
    axis.tready = 1'b1;
    chk("busy_cleared", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("packet_count", pcount, pc_exp);
    chk("all_beats_seen", sb.size(), 0);
  endtask

  task automatic chk_all_zero(input string phase);
    chk({phase, "_tvalid"}, axis.tvalid, 0);
    chk({phase, "_tlast"},  axis.tlast,  0);
    chk({phase, "_tdata"},  axis.tdata,  0);
    chk({phase, "_tstrb"},  axis.tstrb,  0);
    chk({phase, "_busy"},   busy,        0);
    chk({phase, "_done"},   done,        0);
    chk({phase, "_pcount"}, pcount,      0);
  endtask

  initial begin
    axis.tready = 1'b1;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    //  len, pkts, gap, seed,         bp, poke, cycles, tvalid pattern
    run(8,   1,    0,   32'h10,       0,  0,    3,      64'h6);
    run(6,   1,    0,   32'h20,       0,  0,    3,      64'h6);
    run(1,   1,    0,   32'h30,       0,  0,    2,      64'h2);
    run(4,   3,    2,   32'h40,       0,  0,    8,      64'h92);
    run(4,   3,    0,   32'h50,       0,  0,    4,      64'hE);
    run(64,  2,    1,   32'hFFFF_FFF0, 1, 0,    0,      64'h0);
    run(0,   5,    0,   32'h60,       0,  0,    1,      64'h0);
    run(8,   0,    0,   32'h61,       0,  0,    1,      64'h0);
    run(16,  1,    0,   32'h70,       0,  1,    5,      64'h1E);

    // Reset while beat 3 of 16 is on the bus.
    push_expected(64, 1, 32'h200);
    cfg_len  = 16'd64;
    cfg_pkts = 16'd1;
    cfg_gap  = 8'd0;
    cfg_seed = 32'h200;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("beat3_presented", axis.tdata, 32'h203);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    pc_exp = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_valid", axis.tvalid, 0);
    run(8,   1,    0,   32'h300,      0,  0,    3,      64'h6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
